// File: rtl/apb_reg_bank_pkg.sv
// Shared widths, FSM encoding and byte-merge helper
// for the APB register bank.
package apb_reg_bank_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = 4;
  localparam int unsigned CntWidth  = 3;

  typedef enum logic {
    StIdle,
    StAccess
  } state_e;

  function automatic logic [DataWidth-1:0] byte_merge(
    input logic [DataWidth-1:0] old_v,
    input logic [DataWidth-1:0] new_v,
    input logic [StrbWidth-1:0] strb
  );
    logic [DataWidth-1:0] r;
    r = old_v;
    for (int b = 0; b < StrbWidth; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_reg_cell.sv
// One 32-bit register: full-word hardware load, then
// strobed APB bytes layered on top in the same cycle.
// Ports: clk_i/rst_ni, apb_we_i/apb_wdata_i/apb_strb_i,
// hw_we_i/hw_wdata_i, q_o (current value).
module apb_reg_cell
  import apb_reg_bank_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 apb_we_i,
  input  logic [DataWidth-1:0] apb_wdata_i,
  input  logic [StrbWidth-1:0] apb_strb_i,
  input  logic                 hw_we_i,
  input  logic [DataWidth-1:0] hw_wdata_i,
  output logic [DataWidth-1:0] q_o
);

  logic [DataWidth-1:0] q_q, q_d;

  // APB strobed bytes win over hardware data.
  always_comb begin
    q_d = q_q;
    if (hw_we_i) q_d = hw_wdata_i;
    if (apb_we_i) begin
      q_d = byte_merge(q_d, apb_wdata_i, apb_strb_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/apb_reg_bank.sv
// APB slave register bank: FSM, wait counter, decode.
// Ports: APB (psel/penable/pwrite/paddr/pwdata/pstrb,
// prdata/pready/pslverr), hw_we_i/hw_wdata_i update,
// reg_q_o contents, wr_pulse_o post-write strobes.
module apb_reg_bank
  import apb_reg_bank_pkg::*;
#(
  parameter int unsigned NumRegs    = 8,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned WaitStates = 0,
  parameter logic [NumRegs-1:0] RoMask = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic [31:0]            pwdata_i,
  input  logic [3:0]             pstrb_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  input  logic [NumRegs-1:0]     hw_we_i,
  input  logic [NumRegs*32-1:0]  hw_wdata_i,
  output logic [NumRegs*32-1:0]  reg_q_o,
  output logic [NumRegs-1:0]     wr_pulse_o
);

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [NumRegs-1:0]   wr_pulse_q, wr_pulse_d;
  logic [NumRegs-1:0]   hit, apb_we;
  logic [DataWidth-1:0] regs [NumRegs];
  logic [DataWidth-1:0] rd_mux;
  logic [63:0]          idx;
  logic                 in_range, ro_hit, err, ready;
  logic                 commit;
  logic                 unused_addr;

  assign unused_addr = ^paddr_i[1:0];
  assign idx = 64'(paddr_i[AddrWidth-1:2]);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NumRegs; i++) begin
      hit[i] = (idx == 64'(i));
    end
  end

  assign in_range = |hit;
  assign ro_hit   = |(hit & RoMask);
  assign err      = !in_range || (pwrite_i && ro_hit);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (hit[i]) rd_mux = rd_mux | regs[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Dropping psel mid-access aborts with no commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (psel_i && !penable_i) begin
          state_d = StAccess;
          cnt_d   = CntWidth'(WaitStates);
        end
      end
      StAccess: begin
        if (!psel_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (penable_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = (state_q == StAccess) && (cnt_q == '0)
         && psel_i && penable_i;
    commit     = ready && pwrite_i && !err;
    apb_we     = hit & {NumRegs{commit}};
    wr_pulse_d = apb_we;
    pready_o   = ready;
    pslverr_o  = ready && err;
    prdata_o   = (ready && !pwrite_i && !err) ? rd_mux : '0;
  end

  assign wr_pulse_o = wr_pulse_q;

  for (genvar g = 0; g < NumRegs; g++) begin : g_cell
    apb_reg_cell u_cell (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .apb_we_i    (apb_we[g]),
      .apb_wdata_i (pwdata_i),
      .apb_strb_i  (pstrb_i),
      .hw_we_i     (hw_we_i[g]),
      .hw_wdata_i  (hw_wdata_i[g*32 +: 32]),
      .q_o         (regs[g])
    );
    assign reg_q_o[g*32 +: 32] = regs[g];
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: zero-wait and 3-wait instances
// against an array model of the register file.
module tb_apb_reg_bank;

  logic         clk = 0;
  logic         rst_n = 1;
  logic         psel0 = 0, psel3 = 0;
  logic         penable = 0, pwrite = 0;
  logic [31:0]  paddr = '0, pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic [31:0]  prdata0, prdata3;
  logic         pready0, pready3, pslverr0, pslverr3;
  logic [7:0]   hw_we0 = '0, hw_we3 = '0;
  logic [255:0] hw_wdata = '0;
  logic [255:0] reg_q0, reg_q3;
  logic [7:0]   wr_pulse0, wr_pulse3;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [2][8];

  always #5 clk = ~clk;

  apb_reg_bank #(
    .NumRegs(8), .AddrWidth(32), .WaitStates(0),
    .RoMask(8'h80)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel0),
    .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata0), .pready_o(pready0),
    .pslverr_o(pslverr0), .hw_we_i(hw_we0),
    .hw_wdata_i(hw_wdata), .reg_q_o(reg_q0),
    .wr_pulse_o(wr_pulse0)
  );

  apb_reg_bank #(
    .NumRegs(8), .AddrWidth(32), .WaitStates(3),
    .RoMask(8'h80)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel3),
    .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata3), .pready_o(pready3),
    .pslverr_o(pslverr3), .hw_we_i(hw_we3),
    .hw_wdata_i(hw_wdata), .reg_q_o(reg_q3),
    .wr_pulse_o(wr_pulse3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic m_err(input bit wr,
                                 input logic [31:0] a);
    return (a[31:2] >= 8) || (wr && a[31:2] == 7);
  endfunction

  task automatic m_write(input int d,
                         input logic [31:0] a,
                         input logic [31:0] v,
                         input logic [3:0] s);
    if (!m_err(1'b1, a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[d][a[4:2]][8*b +: 8] = v[8*b +: 8];
      end
    end
  endtask

  function automatic logic [31:0] m_read(input int d,
                                         input logic [31:0] a);
    if (m_err(1'b0, a)) return 32'h0;
    return mdl[d][a[4:2]];
  endfunction

  function automatic logic [31:0] regq(input int d,
                                       input int i);
    logic [255:0] v;
    v = (d == 0) ? reg_q0 : reg_q3;
    return v[i*32 +: 32];
  endfunction

  task automatic chk_regs(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s_d%0d_r%0d", tag, d, i),
            regq(d, i), mdl[d][i]);
      end
    end
  endtask

  task automatic xfer(input int d, input bit chain,
                      input bit wr, input logic [31:0] a,
                      input logic [31:0] v,
                      input logic [3:0] s,
                      output logic [31:0] rd,
                      output logic er, output int waits);
    bit done;
    if (!chain) begin
      @(posedge clk); #1;
    end
    if (d == 0) psel0 = 1; else psel3 = 1;
    penable = 0; pwrite = wr; paddr = a;
    pwdata = v; pstrb = s;
    @(posedge clk); #1;
    penable = 1;
    waits = 0; done = 0; rd = 'x; er = 'x;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((d == 0) ? pready0 : pready3) begin
        rd = (d == 0) ? prdata0 : prdata3;
        er = (d == 0) ? pslverr0 : pslverr3;
        done = 1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    chk("ready_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    psel0 = 0; psel3 = 0; penable = 0;
  endtask

  task automatic pulse_chk(input int d,
                           input logic [7:0] exp);
    @(negedge clk);
    chk("pulse_on", 32'((d == 0) ? wr_pulse0 : wr_pulse3),
        32'(exp));
    @(negedge clk);
    chk("pulse_off", 32'((d == 0) ? wr_pulse0 : wr_pulse3),
        32'h0);
  endtask

  task automatic do_write(input string tag, input int d,
                          input logic [31:0] a,
                          input logic [31:0] v,
                          input logic [3:0] s);
    logic [31:0] rd;
    logic er;
    int w;
    logic eer;
    eer = m_err(1'b1, a);
    xfer(d, 1'b0, 1'b1, a, v, s, rd, er, w);
    m_write(d, a, v, s);
    chk({tag, "_err"}, 32'(er), 32'(eer));
    chk({tag, "_wait"}, w, (d == 0) ? 0 : 3);
    pulse_chk(d, eer ? 8'h0 : (8'h1 << a[4:2]));
  endtask

  task automatic do_read(input string tag, input int d,
                         input bit chain,
                         input logic [31:0] a);
    logic [31:0] rd;
    logic er;
    int w;
    logic [31:0] exp;
    exp = m_read(d, a);
    xfer(d, chain, 1'b0, a, 32'h0, 4'h0, rd, er, w);
    chk({tag, "_rdata"}, rd, exp);
    chk({tag, "_err"}, 32'(er), 32'(m_err(1'b0, a)));
    chk({tag, "_wait"}, w, (d == 0) ? 0 : 3);
  endtask

  initial begin
    logic [31:0] rd, a, v;
    logic [3:0] s;
    logic er;
    int w, d;
    bit wr;
    logic [7:0] m;

    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < 8; i++) mdl[dd][i] = '0;

    #1 rst_n = 0;
    #2;
    chk("rst_pready", 32'({pready0, pready3}), 32'h0);
    chk("rst_pslverr", 32'({pslverr0, pslverr3}), 32'h0);
    chk("rst_prdata0", prdata0, 32'h0);
    chk("rst_pulse", 32'({wr_pulse0, wr_pulse3}), 32'h0);
    chk_regs("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // Zero-wait write and its pulse.
    do_write("w04", 0, 32'h04, 32'hDEADBEEF, 4'hF);
    chk("w04_reg", regq(0, 1), 32'hDEADBEEF);

    // Three wait states on the read back.
    do_write("w04_d3", 1, 32'h04, 32'hDEADBEEF, 4'hF);
    do_read("r04_d3", 1, 1'b0, 32'h04);

    // Partial strobes.
    do_write("strb5", 0, 32'h04, 32'h11223344, 4'h5);
    chk("strb5_reg", regq(0, 1), 32'hDE22BE44);

    // Errors: out of range and read-only.
    do_write("oor", 0, 32'h20, 32'h12345678, 4'hF);
    do_write("ro", 0, 32'h1C, 32'h12345678, 4'hF);
    do_read("oor_rd", 0, 1'b0, 32'h20);
    chk_regs("err");

    // Zero-strobe write still pulses.
    do_write("strb0", 0, 32'h10, 32'hFFFFFFFF, 4'h0);

    // Back-to-back write then read, no idle cycle.
    xfer(0, 1'b0, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF,
         rd, er, w);
    m_write(0, 32'h0C, 32'hCAFEF00D, 4'hF);
    do_read("b2b", 0, 1'b1, 32'h0F);
    xfer(1, 1'b0, 1'b1, 32'h08, 32'h0BADCAFE, 4'hF,
         rd, er, w);
    m_write(1, 32'h08, 32'h0BADCAFE, 4'hF);
    do_read("b2b_d3", 1, 1'b1, 32'h08);

    // Hardware and APB on the same edge.
    hw_wdata[95:64] = 32'h55555555;
    hw_we0 = 8'h04;
    xfer(0, 1'b0, 1'b1, 32'h08, 32'hAAAAAAAA, 4'h3,
         rd, er, w);
    hw_we0 = 8'h00;
    mdl[0][2] = 32'h55555555;
    m_write(0, 32'h08, 32'hAAAAAAAA, 4'h3);
    @(negedge clk);
    chk("hw_apb", regq(0, 2), 32'h5555AAAA);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        m = 8'($urandom);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++)
          hw_wdata[i*32 +: 32] = $urandom;
        if (d == 0) hw_we0 = m; else hw_we3 = m;
        @(posedge clk); #1;
        hw_we0 = 0; hw_we3 = 0;
        for (int i = 0; i < 8; i++)
          if (m[i]) mdl[d][i] = hw_wdata[i*32 +: 32];
      end
      wr = 1'($urandom);
      a = 32'($urandom_range(0, 39));
      v = $urandom;
      s = 4'($urandom);
      if (wr) do_write("rnd_w", d, a, v, s);
      else    do_read("rnd_r", d, 1'b0, a);
    end
    chk_regs("rnd");

    // Reset in the middle of a waited write.
    @(posedge clk); #1;
    psel3 = 1; penable = 0; pwrite = 1;
    paddr = 32'h0C; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < 8; i++) mdl[dd][i] = '0;
    chk("mrst_pready", 32'(pready3), 32'h0);
    chk("mrst_pslverr", 32'(pslverr3), 32'h0);
    chk("mrst_prdata", prdata3, 32'h0);
    chk("mrst_pulse", 32'(wr_pulse3), 32'h0);
    chk("mrst_reg3", regq(1, 3), 32'h0);
    @(negedge clk);
    psel3 = 0; penable = 0;
    rst_n = 1;
    @(negedge clk);
    chk("mrst_after", regq(1, 3), 32'h0);
    do_write("post_rst", 1, 32'h0C, 32'h87654321, 4'hF);
    chk("post_rst_reg", regq(1, 3), 32'h87654321);
    chk_regs("end");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_reg_bank.md
APB_REG_BANK -- requirements
Module: apb_reg_bank

Interface
REQ-001 SHALL have parameter NumRegs, default 8, number of 32-bit registers (1..64).
REQ-002 SHALL have parameter AddrWidth, default 32, APB address width.
REQ-003 SHALL have parameter WaitStates, default 0, extra access-phase cycles before pready_o (0..7).
REQ-004 SHALL have parameter RoMask, NumRegs bits, default '0; bit i=1 makes register i read-only to APB.
REQ-005 SHALL have port clk_i  input  1  clock; single clock domain, all logic on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port psel_i  input  1  APB select.
REQ-008 SHALL have port penable_i  input  1  APB enable.
REQ-009 SHALL have port pwrite_i  input  1  APB write=1/read=0.
REQ-010 SHALL have port paddr_i  input  AddrWidth  APB byte address.
REQ-011 SHALL have port pwdata_i  input  32  write data.
REQ-012 SHALL have port pstrb_i  input  4  byte write strobes.
REQ-013 SHALL have port prdata_o  output  32  read data.
REQ-014 SHALL have port pready_o  output  1  transfer complete.
REQ-015 SHALL have port pslverr_o  output  1  transfer error, valid only with pready_o.
REQ-016 SHALL have port hw_we_i  input  NumRegs  per-register hardware update enable.
REQ-017 SHALL have port hw_wdata_i  input  NumRegs*32  hardware update data, register i at bits [32i+31:32i].
REQ-018 SHALL have port reg_q_o  output  NumRegs*32  current register contents, same packing.
REQ-019 SHALL have port wr_pulse_o  output  NumRegs  one-cycle pulse after a successful APB write to register i.

Function
REQ-020 SHALL implement FSM IDLE -> ACCESS -> IDLE; IDLE->ACCESS when psel_i=1 and penable_i=0; load wait counter with WaitStates.
REQ-021 In ACCESS, counter SHALL decrement each cycle while non-zero; pready_o=1 combinationally when counter=0 and psel_i=penable_i=1; then return to IDLE.
REQ-022 pready_o SHALL be 0 in IDLE and while counter non-zero; WaitStates=0 gives zero-wait APB (pready_o in first access cycle).
REQ-023 If psel_i drops during ACCESS (protocol violation), FSM SHALL return to IDLE without committing any write.
REQ-024 Index SHALL be paddr_i[AddrWidth-1:2]; paddr_i[1:0] ignored.
REQ-025 Error (pslverr_o=1 with pready_o) SHALL occur for index >= NumRegs, or write to RoMask register; no register changes on error; read error returns prdata_o=0.
REQ-026 Successful write SHALL update, on the pready_o cycle edge, only bytes with pstrb_i set; pstrb_i=0 is a legal no-op write that still pulses wr_pulse_o.
REQ-027 wr_pulse_o[i] SHALL be asserted exactly the cycle after the committing edge, one cycle wide.
REQ-028 prdata_o SHALL equal the addressed register's value before any same-cycle update while pready_o=1; 0 otherwise.
REQ-029 hw_we_i[i]=1 SHALL load full 32 bits of hw_wdata_i into register i on that edge, for RO and RW registers.
REQ-030 Simultaneous APB write and hw_we_i on same register: APB-strobed bytes SHALL take APB data, unstrobed bytes take hardware data.
REQ-031 Back-to-back transfers SHALL be supported: a new setup phase in the cycle after pready_o is accepted with no idle gap.

Reset
REQ-032 On rst_ni=0, asynchronously: all registers 0, FSM IDLE, counter 0, wr_pulse_o 0, pready_o 0, pslverr_o 0, prdata_o 0.
REQ-033 Reset asserted mid-transfer SHALL abort it with no register write; first post-reset transfer behaves normally.

Structure
REQ-034 Register data width (32), strobe width (4) and FSM state enum SHALL live in shared package apb_reg_bank_pkg.
REQ-035 Per-register storage with byte-merge logic SHALL be sub-module apb_reg_cell, instantiated NumRegs times; FSM and decode in top.

Verification
REQ-036 Write 0xDEADBEEF to 0x04, strb 0xF, WaitStates=0 -> pready_o in first access cycle, reg 1 = 0xDEADBEEF, wr_pulse_o[1] one cycle next.
REQ-037 WaitStates=3, read 0x04 -> pready_o after exactly 3 wait cycles, prdata_o=0xDEADBEEF, pslverr_o=0.
REQ-038 Reg 1 = 0xDEADBEEF, write 0x11223344 strb 0x5 -> reg 1 = 0xDE22BE44.
REQ-039 NumRegs=8, write to 0x20 and to RoMask register -> pslverr_o=1, no register change, no wr_pulse_o.
REQ-040 Same-edge APB write 0xAAAAAAAA strb 0x3 and hw_we_i 0x55555555 on reg 2 -> reg 2 = 0x5555AAAA.
REQ-041 rst_ni low during WaitStates=3 write access -> all outputs 0, target register unchanged, next write succeeds.
